// File: rtl/branch_target_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_target_predictor_pkg
// Shared definitions for the IF-side branch target predictor: the codebase
// word-width defines, BTB entry field widths, sweep FSM state encodings and
// the 2-bit direction counter constants.
// ---------------------------------------------------------------------------
package branch_target_predictor_pkg;

    localparam int AddrLen = 32;
    localparam logic [AddrLen-1:0] ZERO_WORD = '0;

    // BTB entry field widths (tag width depends on ADDR_W/IDX_W and is
    // derived in the top module).
    localparam int CTR_W   = 2;
    localparam int VALID_W = 1;
    localparam int JAL_W   = 1;

    // Direction counter: values 2'b10 and 2'b11 predict taken.
    localparam logic [CTR_W-1:0] CTR_MIN     = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = 2'b10;
    localparam logic [CTR_W-1:0] CTR_MAX     = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } btb_state_e;

endpackage

// File: rtl/branch_target_predictor_btb_sat_counter.sv
// ---------------------------------------------------------------------------
// btb_sat_counter
// Next-state logic of a 2-bit saturating direction counter.
//   ctr_i      current counter value
//   taken_i    resolved direction (1 = increment, 0 = decrement)
//   ctr_next_o counter value after the update, clamped to [00, 11]
// ---------------------------------------------------------------------------
module btb_sat_counter
    import branch_target_predictor_pkg::*;
(
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_next_o
);

    always_comb begin
        ctr_next_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) begin
                ctr_next_o = ctr_i + 2'b01;
            end
        end else begin
            if (ctr_i != CTR_MIN) begin
                ctr_next_o = ctr_i - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped BTB with per-entry 2-bit direction counters. IF gets a
// combinational next-PC prediction; EX resolutions update the table on the
// clock edge. After reset a sweep clears every entry before predictions are
// enabled. Lookup and mispredict performance counters are kept while ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   lk_pc, lk_valid   fetch PC and fetch-issued qualifier
//   pred_pc, pred_hit predicted next PC, table hit flag
//   ready             table initialised, predictions valid
//   upd_*             branch resolution from EX
//   stat_lookups      lk_valid cycles while ready
//   stat_mispredicts  upd_valid && upd_mispredict cycles while ready
//
// State   | meaning
// --------+-------------------------------------------------
// ST_INIT | clearing one entry per cycle, predictions off
// ST_RUN  | normal lookup/update operation
// ---------------------------------------------------------------------------
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] lk_pc,
    input  logic              lk_valid,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              pred_hit,
    output logic              ready,

    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_is_jal,
    input  logic              upd_mispredict,

    output logic [CNT_W-1:0]  stat_lookups,
    output logic [CNT_W-1:0]  stat_mispredicts
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W - 2;
    localparam logic [IDX_W-1:0]  SWEEP_LAST = '1;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    // Table storage: plain flop arrays, cleared by the sweep rather than rst.
    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic               jal_q    [ENTRIES];

    btb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [CNT_W-1:0]   lookups_q, lookups_d;
    logic [CNT_W-1:0]   mispred_q, mispred_d;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic [CTR_W-1:0]   ctr_next;
    logic               run;

    // Byte-offset bits never participate in index or tag.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    assign run     = (state_q == ST_RUN);
    assign ready   = run;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sweep_d = '0;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lookup: reads the pre-edge table, so a same-cycle update to the same
    // index is only seen on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pred_hit = run && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_pc  = lk_pc + PC_STEP;
        if (pred_hit && (jal_q[lk_idx] || ctr_q[lk_idx][1])) begin
            pred_pc = target_q[lk_idx];
        end
    end

    // ------------------------------------------------------------------
    // Update
    // ------------------------------------------------------------------
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    btb_sat_counter u_sat_counter (
        .ctr_i      (ctr_q[upd_idx]),
        .taken_i    (upd_taken),
        .ctr_next_o (ctr_next)
    );

    // rst gates all table writes so an update in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                valid_q[sweep_q] <= 1'b0;
                ctr_q[sweep_q]   <= CTR_WEAK_NT;
            end else if (upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= ctr_next;
                    if (upd_taken) begin
                        target_q[upd_idx] <= upd_target;
                        jal_q[upd_idx]    <= upd_is_jal;
                    end
                end else if (upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= upd_target;
                    jal_q[upd_idx]    <= upd_is_jal;
                    ctr_q[upd_idx]    <= CTR_WEAK_T;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2**CNT_W)
    // ------------------------------------------------------------------
    always_comb begin
        lookups_d = lookups_q;
        mispred_d = mispred_q;
        if (run && lk_valid) begin
            lookups_d = lookups_q + CNT_W'(1);
        end
        if (run && upd_valid && upd_mispredict) begin
            mispred_d = mispred_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_target_predictor
// Directed bench for branch_target_predictor. Inputs change 1 time unit after
// the rising edge; outputs are checked before the next rising edge.
// ---------------------------------------------------------------------------
module tb_branch_target_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lk_pc;
    logic        lk_valid;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_jal;
    logic        upd_mispredict;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    int n_tests;
    int n_fail;

    branch_target_predictor #(
        .ADDR_W (32),
        .IDX_W  (6),
        .CNT_W  (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lk_pc            (lk_pc),
        .lk_valid         (lk_valid),
        .pred_pc          (pred_pc),
        .pred_hit         (pred_hit),
        .ready            (ready),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_is_jal       (upd_is_jal),
        .upd_mispredict   (upd_mispredict),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle update pulse from EX.
    task automatic update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic jal, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_is_jal     = jal;
        upd_mispredict = mis;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic [31:0] exp_pc, input logic exp_hit);
        lk_pc = pc;
        #1;
        check({tag, "_pc"}, pred_pc, exp_pc);
        check({tag, "_hit"}, {31'b0, pred_hit}, {31'b0, exp_hit});
    endtask

    // Waits for ready with a cycle budget; returns cycles spent with ready=0.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        lk_pc          = 32'h0;
        lk_valid       = 1'b0;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_is_jal     = 1'b0;
        upd_mispredict = 1'b0;

        repeat (3) step();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_lookups", stat_lookups, 32'd0);
        check("rst_mispred", stat_mispredicts, 32'd0);

        // Reset sweep: lookups during the sweep miss and are not counted.
        rst      = 1'b0;
        lk_valid = 1'b1;
        lookup("sweep_lk", 32'h0000_0100, 32'h0000_0104, 1'b0);
        wait_ready(cyc);
        check("sweep_len", cyc, 32'd64);
        lk_valid = 1'b0;
        check("sweep_no_count", stat_lookups, 32'd0);
        lookup("empty_lk", 32'h0000_0200, 32'h0000_0204, 1'b0);

        // Allocate then predict.
        update(32'h0000_0200, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        lookup("alloc_hit", 32'h0000_0200, 32'h0000_0080, 1'b1);
        lookup("alloc_nb", 32'h0000_0204, 32'h0000_0208, 1'b0);

        // Hysteresis: 10 -> 01 (not taken, still hits).
        update(32'h0000_0200, 1'b0, 32'h0, 1'b0, 1'b0);
        lookup("hyst_01", 32'h0000_0200, 32'h0000_0204, 1'b1);
        // 01 -> 10 -> 11
        update(32'h0000_0200, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        update(32'h0000_0200, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        // 11 -> 10 still taken proves the counter reached 11.
        update(32'h0000_0200, 1'b0, 32'h0, 1'b0, 1'b0);
        lookup("hyst_sat_hi", 32'h0000_0200, 32'h0000_0080, 1'b1);
        // 10 -> 01 -> 00 -> 00, then one taken -> 01 still not taken.
        repeat (3) update(32'h0000_0200, 1'b0, 32'h0, 1'b0, 1'b0);
        lookup("hyst_00", 32'h0000_0200, 32'h0000_0204, 1'b1);
        update(32'h0000_0200, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        lookup("hyst_sat_lo", 32'h0000_0200, 32'h0000_0204, 1'b1);
        update(32'h0000_0200, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        lookup("hyst_10", 32'h0000_0200, 32'h0000_0080, 1'b1);

        // Same-cycle hazard: lookup sees pre-update ctr=10.
        lk_pc          = 32'h0000_0200;
        upd_valid      = 1'b1;
        upd_pc         = 32'h0000_0200;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_is_jal     = 1'b0;
        #1;
        check("hazard_same", pred_pc, 32'h0000_0080);
        step();
        upd_valid = 1'b0;
        lookup("hazard_next", 32'h0000_0200, 32'h0000_0204, 1'b1);

        // Aliasing: 0x1200 shares index 0 with 0x200.
        update(32'h0000_0200, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        update(32'h0000_1200, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        lookup("alias_old", 32'h0000_0200, 32'h0000_0204, 1'b0);
        lookup("alias_new", 32'h0000_1200, 32'h0000_0300, 1'b1);

        // JAL: predicts taken even after ctr drops to 01.
        update(32'h0000_0408, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
        update(32'h0000_0408, 1'b0, 32'h0, 1'b1, 1'b0);
        lookup("jal_taken", 32'h0000_0408, 32'h0000_0040, 1'b1);

        // Miss, not taken: no allocation.
        update(32'h0000_050C, 1'b0, 32'h0000_0777, 1'b0, 1'b0);
        lookup("miss_nt", 32'h0000_050C, 32'h0000_0510, 1'b0);

        // PC wrap on fall-through.
        lookup("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

        // Stats: 5 lookups, 2 mispredicts (not-taken misses, no table change).
        check("pre_lookups", stat_lookups, 32'd0);
        lk_valid = 1'b1;
        repeat (5) step();
        lk_valid = 1'b0;
        update(32'h0000_0310, 1'b0, 32'h0, 1'b0, 1'b1);
        update(32'h0000_0314, 1'b0, 32'h0, 1'b0, 1'b1);
        check("stat_lookups", stat_lookups, 32'd5);
        check("stat_mispred", stat_mispredicts, 32'd2);

        // Mid-run reset, with an update in the reset cycle.
        rst            = 1'b1;
        upd_valid      = 1'b1;
        upd_pc         = 32'h0000_0600;
        upd_taken      = 1'b1;
        upd_target     = 32'h0000_0123;
        upd_is_jal     = 1'b0;
        upd_mispredict = 1'b1;
        step();
        rst            = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        check("mid_rst_lookups", stat_lookups, 32'd0);
        check("mid_rst_mispred", stat_mispredicts, 32'd0);
        wait_ready(cyc);
        check("mid_sweep_len", cyc, 32'd64);
        lookup("gone_1200", 32'h0000_1200, 32'h0000_1204, 1'b0);
        lookup("gone_408", 32'h0000_0408, 32'h0000_040C, 1'b0);
        lookup("dropped_600", 32'h0000_0600, 32'h0000_0604, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- IF-side next-PC predictor: the consumer of the branch-resolution outputs produced by EX (taken flag, resolved target, mispredict flag).
- Direct-mapped BTB with a 2-bit saturating direction counter per entry.
- Combinational same-cycle lookup for IF; registered single-cycle update from EX.
- Runs a post-reset table-clear sweep FSM, and keeps lookup/mispredict performance counters.

Parameters:
- ADDR_W, 32, PC/target width.
- IDX_W, 6, index bits; table holds 2**IDX_W entries.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- lk_pc  in  ADDR_W  PC being fetched this cycle
- lk_valid  in  1  IF is issuing a fetch this cycle
- pred_pc  out  ADDR_W  predicted next PC for lk_pc
- pred_hit  out  1  lookup hit a valid entry with matching tag
- ready  out  1  table initialised; predictions valid
- upd_valid  in  1  EX resolved a control-flow instruction this cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  branch taken (always 1 for JAL)
- upd_target  in  ADDR_W  resolved jump target
- upd_is_jal  in  1  unconditional jump
- upd_mispredict  in  1  EX signalled a redirect
- stat_lookups  out  CNT_W  count of lk_valid cycles while ready
- stat_mispredicts  out  CNT_W  count of upd_valid && upd_mispredict while ready

Behaviour:
- Reset: rst is synchronous, active-high. While asserted: FSM to INIT, sweep index to 0, ready=0, both stats=0.
- Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W], ctr[2], jal.
- Index: pc[IDX_W+1:2]. pc[1:0] is ignored.
- FSM INIT:
  - Each cycle clears entry[sweep] (valid=0, ctr=2'b01), then increments sweep.
  - After clearing entry 2**IDX_W-1, moves to RUN.
  - ready=1 from the first RUN cycle, i.e. 2**IDX_W cycles after rst deasserts.
- FSM RUN: stays in RUN until rst.
- Reset mid-operation (rst in either state): returns to INIT with sweep=0. Stats clear. Any in-flight update is dropped.
- Lookup (combinational, zero latency):
  - pred_hit = ready && valid && tag match.
  - pred_pc = upd target when pred_hit && (jal || ctr[1]); otherwise lk_pc+4, wrapping modulo 2**ADDR_W.
  - When ready=0: pred_hit=0, pred_pc=lk_pc+4.
- Update (registered, takes effect at the clock edge of upd_valid; ignored when ready=0):
  - Hit, taken: ctr saturating-increments (max 2'b11); target and jal are overwritten.
  - Hit, not taken: ctr saturating-decrements (min 2'b00); entry stays valid.
  - Miss, taken: allocate/replace entry with valid=1, tag, target, jal, ctr=2'b10.
  - Miss, not taken: no table change.
- Same cycle, same index: lookup returns the pre-update contents. The new state is visible the next cycle. No bypass.
- Stats:
  - Increment at the clock edge.
  - Wrap to 0 at 2**CNT_W.
  - Do not count when ready=0.
- JAL entries always predict taken. Their ctr is still updated but is not used for JAL prediction.

Decomposition:
- Shared package:
  - Entry field widths and FSM state encodings (ST_INIT, ST_RUN).
  - Counter constants: CTR_WEAK_T=2'b10, CTR_WEAK_NT=2'b01.
  - These sit with the existing AddrLen/ZERO_WORD defines.
- One natural sub-module: btb_sat_counter, a 2-bit saturating counter with next-state logic.
- The table remains flop arrays inside the top module.

Test Plan:
- Reset sweep: hold rst 3 cycles, release. ready=0 for exactly 64 cycles, then 1. Lookup at 0x100 during the sweep gives pred_pc=0x104, pred_hit=0.
- Allocate then predict: update pc=0x200, taken, target=0x080. Next-cycle lookup 0x200 gives pred_hit=1, pred_pc=0x080. Lookup 0x204 gives 0x208.
- Counter hysteresis: after allocate (ctr=10), one not-taken update leaves ctr=01, and lookup 0x200 gives 0x204 with pred_hit=1. Two taken updates give ctr=11. Three not-taken updates saturate at 00.
- Aliasing: allocate 0x200, then update pc=0x1200 (same index, different tag) taken to 0x300. Lookup 0x200 gives pred_hit=0, pred_pc=0x204.
- Same-cycle hazard: with 0x200 at ctr=10, in one cycle look up 0x200 and update 0x200 not-taken. That cycle gives 0x080; the next cycle gives 0x204.
- Stats and mid-run reset: 5 lookups and 2 mispredict updates give stat_lookups=5, stat_mispredicts=2. Pulse rst: stats=0, ready=0, and the prior entry is gone after the sweep.
